fht_unload: RTL

Readout engine for the FHT result RAM. After a transform completes, it walks the four RAM banks of `fht_top` through the read ports `iADDR_RD_0..3` / `oDATA_0..3`, undoes the bit-reversed row order and emits the spectrum as one serial word stream with a valid/ready handshake. It sits between `fht_top` and any downstream consumer: a second transform stage, a DMA engine or a display path. It is the read-side counterpart of the row-by-row, bank-by-bank loader that fills the RAM.

---
 rtl/fht_unload.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fht_unload.sv
// Streams the FHT result RAM out as one valid/ready word sequence: one row of four
// banks per fetch, rows visited in bit-reversed order so the spectrum leaves in natural order.
module fht_unload #(
    parameter int D_BIT   = 18,
    parameter int A_BIT   = 8,
    parameter int RD_LAT  = 2,
    parameter int BIT_REV = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [A_BIT+1:0] oINDEX,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [A_BIT-1:0] ROW_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, SEND} state_t;

    state_t state, state_n;
    logic [A_BIT-1:0] row, row_n, row_inc;
    logic [A_BIT-1:0] addr, addr_n;
    logic [1:0] bank, bank_n, bank_inc;
    logic [LAT_W-1:0] lat, lat_n;
    logic [D_BIT-1:0] row_buf [4];
    logic [D_BIT-1:0] row_buf_n [4];
    logic [D_BIT-1:0] data, data_n;
    logic [A_BIT+1:0] index, index_n;
    logic valid, valid_n;
    logic last, last_n;
    logic busy, busy_n;
    logic done, done_n;
    logic capture;

    function automatic logic [A_BIT-1:0] row_addr(input logic [A_BIT-1:0] x);
        logic [A_BIT-1:0] r;
        r = x;
        if (BIT_REV != 0) begin
            for (int i = 0; i < A_BIT; i++) r[i] = x[A_BIT-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state <= IDLE;
            row   <= '0;
            addr  <= '0;
            bank  <= '0;
            lat   <= '0;
            for (int i = 0; i < 4; i++) row_buf[i] <= '0;
            data  <= '0;
            index <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            addr  <= addr_n;
            bank  <= bank_n;
            lat   <= lat_n;
            for (int i = 0; i < 4; i++) row_buf[i] <= row_buf_n[i];
            data  <= data_n;
            index <= index_n;
            valid <= valid_n;
            last  <= last_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Every output is computed one cycle ahead here so the ports come straight from flops.
    always_comb begin
        state_n   = state;
        row_n     = row;
        addr_n    = addr;
        bank_n    = bank;
        lat_n     = lat;
        row_buf_n = row_buf;
        data_n    = data;
        index_n   = index;
        valid_n   = valid;
        last_n    = last;
        busy_n    = busy;
        done_n    = 1'b0;
        capture   = 1'b0;
        bank_inc  = bank + 2'd1;
        row_inc   = row + 1'b1;

        case (state)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (iSTART) begin
                    row_n   = '0;
                    addr_n  = row_addr('0);
                    bank_n  = '0;
                    busy_n  = 1'b1;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                lat_n = '0;
                if (RD_LAT == 0) capture = 1'b1;
                else             state_n = WAIT;
            end
            WAIT: begin
                if (lat == LAT_END) capture = 1'b1;
                else                lat_n   = lat + 1'b1;
            end
            SEND: begin
                if (iREADY) begin
                    if (bank != 2'd3) begin
                        bank_n  = bank_inc;
                        data_n  = row_buf[bank_inc];
                        index_n = {row, bank_inc};
                        last_n  = (row == ROW_MAX) && (bank_inc == 2'd3);
                    end else begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        if (row == ROW_MAX) begin
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            row_n   = row_inc;
                            addr_n  = row_addr(row_inc);
                            state_n = ADDR;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Row data is latched once; backpressure only replays from this buffer.
        if (capture) begin
            row_buf_n[0] = iDATA_0;
            row_buf_n[1] = iDATA_1;
            row_buf_n[2] = iDATA_2;
            row_buf_n[3] = iDATA_3;
            bank_n       = 2'd0;
            data_n       = iDATA_0;
            index_n      = {row, 2'd0};
            valid_n      = 1'b1;
            last_n       = 1'b0;
            state_n      = SEND;
        end
    end

    assign oADDR_RD = addr;
    assign oDATA    = data;
    assign oVALID   = valid;
    assign oINDEX   = index;
    assign oLAST    = last;
    assign oBUSY    = busy;
    assign oDONE    = done;

endmodule
